// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between the ALU and the register file.
// Accepts one instruction per handshake. Non-memory ops write back one cycle
// later. Loads and stores hold the stage until the memory transaction ends.
module mem_stage (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [2:0]  mem_op_i,
  input  logic [31:0] result_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        wen_i,
  output logic        dmem_v_o,
  output logic        dmem_w_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_data_o,
  output logic [3:0]  dmem_mask_o,
  input  logic        dmem_yumi_i,
  input  logic        dmem_v_i,
  input  logic [31:0] dmem_data_i,
  output logic        wb_v_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, WB} state_t;

  localparam logic [2:0] OP_LW  = 3'd1;
  localparam logic [2:0] OP_LBU = 3'd2;
  localparam logic [2:0] OP_SW  = 3'd3;
  localparam logic [2:0] OP_SB  = 3'd4;

  state_t state_reg, state_next;

  // Latched per-transaction context; dmem_* outputs come straight from flops.
  logic        is_store_reg;
  logic        is_byte_reg;
  logic [1:0]  lane_reg;
  logic [4:0]  rd_reg;
  logic        dmem_v_reg, dmem_w_reg;
  logic [31:0] dmem_addr_reg, dmem_data_reg;
  logic [3:0]  dmem_mask_reg;
  logic        wb_v_reg, misalign_reg;
  logic [4:0]  wb_addr_reg;
  logic [31:0] wb_data_reg;

  // Handshake and op decode.
  logic accept;
  logic is_lw, is_lbu, is_sw, is_sb;
  logic lw_misaligned;
  logic start_mem;
  logic accept_none;

  assign ready_o       = (state_reg == IDLE);
  assign accept        = valid_i && ready_o;
  assign is_lw         = (mem_op_i == OP_LW);
  assign is_lbu        = (mem_op_i == OP_LBU);
  assign is_sw         = (mem_op_i == OP_SW);
  assign is_sb         = (mem_op_i == OP_SB);
  assign lw_misaligned = is_lw && (result_i[1:0] != 2'b00);
  assign start_mem     = accept && ((is_lw && !lw_misaligned) || is_lbu || is_sw || is_sb);
  assign accept_none   = accept && !(is_lw || is_lbu || is_sw || is_sb);

  // Byte-lane write enables for SB and byte-lane extraction for LBU.
  logic [3:0] sb_mask;
  logic [7:0] resp_lanes [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign sb_mask[gi]    = (result_i[1:0] == gi[1:0]);
    assign resp_lanes[gi] = dmem_data_i[8*gi +: 8];
  end

  logic [31:0] load_value;
  assign load_value = is_byte_reg ? {24'b0, resp_lanes[lane_reg]} : dmem_data_i;

  // State register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state decode; dmem_v_o is always high while in REQ, so yumi there is live.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start_mem) state_next = REQ;
      REQ:  if (dmem_yumi_i) state_next = is_store_reg ? IDLE : RESP;
      RESP: if (dmem_v_i) state_next = WB;
      WB:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transaction context and memory request outputs, loaded on accept.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      is_store_reg  <= 1'b0;
      is_byte_reg   <= 1'b0;
      lane_reg      <= 2'b00;
      rd_reg        <= 5'd0;
      dmem_v_reg    <= 1'b0;
      dmem_w_reg    <= 1'b0;
      dmem_addr_reg <= 32'd0;
      dmem_data_reg <= 32'd0;
      dmem_mask_reg <= 4'd0;
    end else if (start_mem) begin
      is_store_reg  <= is_sw || is_sb;
      is_byte_reg   <= is_lbu || is_sb;
      lane_reg      <= result_i[1:0];
      rd_reg        <= rd_addr_i;
      dmem_v_reg    <= 1'b1;
      dmem_w_reg    <= is_sw || is_sb;
      dmem_addr_reg <= {result_i[31:2], 2'b00};
      dmem_data_reg <= is_sw ? store_data_i :
                       is_sb ? {4{store_data_i[7:0]}} : 32'd0;
      dmem_mask_reg <= is_sw ? 4'b1111 : is_sb ? sb_mask : 4'b0000;
    end else if (state_reg == REQ && dmem_yumi_i) begin
      dmem_v_reg <= 1'b0;
    end
  end

  // Writeback beat and misalignment pulse.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wb_v_reg     <= 1'b0;
      wb_addr_reg  <= 5'd0;
      wb_data_reg  <= 32'd0;
      misalign_reg <= 1'b0;
    end else begin
      wb_v_reg     <= 1'b0;
      misalign_reg <= accept && lw_misaligned;
      if (accept_none) begin
        wb_v_reg    <= wen_i;
        wb_addr_reg <= rd_addr_i;
        wb_data_reg <= result_i;
      end else if (state_reg == RESP && dmem_v_i) begin
        wb_v_reg    <= 1'b1;
        wb_addr_reg <= rd_reg;
        wb_data_reg <= load_value;
      end
    end
  end

  assign dmem_v_o    = dmem_v_reg;
  assign dmem_w_o    = dmem_w_reg;
  assign dmem_addr_o = dmem_addr_reg;
  assign dmem_data_o = dmem_data_reg;
  assign dmem_mask_o = dmem_mask_reg;
  assign wb_v_o      = wb_v_reg;
  assign wb_addr_o   = wb_addr_reg;
  assign wb_data_o   = wb_data_reg;
  assign misalign_o  = misalign_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage with hand-computed expectations.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [2:0]  mem_op_i = 3'd0;
  logic [31:0] result_i = 32'd0;
  logic [31:0] store_data_i = 32'd0;
  logic [4:0]  rd_addr_i = 5'd0;
  logic        wen_i = 1'b0;
  logic        dmem_v_o, dmem_w_o;
  logic [31:0] dmem_addr_o, dmem_data_o;
  logic [3:0]  dmem_mask_o;
  logic        dmem_yumi_i = 1'b0;
  logic        dmem_v_i = 1'b0;
  logic [31:0] dmem_data_i = 32'd0;
  logic        wb_v_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;
  logic        misalign_o;

  int checks = 0;
  int failures = 0;

  mem_stage dut (
    .clk(clk), .n_reset(n_reset),
    .valid_i(valid_i), .ready_o(ready_o),
    .mem_op_i(mem_op_i), .result_i(result_i), .store_data_i(store_data_i),
    .rd_addr_i(rd_addr_i), .wen_i(wen_i),
    .dmem_v_o(dmem_v_o), .dmem_w_o(dmem_w_o), .dmem_addr_o(dmem_addr_o),
    .dmem_data_o(dmem_data_o), .dmem_mask_o(dmem_mask_o),
    .dmem_yumi_i(dmem_yumi_i), .dmem_v_i(dmem_v_i), .dmem_data_i(dmem_data_i),
    .wb_v_o(wb_v_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] res,
                      input logic [31:0] sd, input logic [4:0] rd, input logic wen);
    valid_i = 1'b1; mem_op_i = op; result_i = res;
    store_data_i = sd; rd_addr_i = rd; wen_i = wen;
  endtask

  task automatic idle_in();
    valid_i = 1'b0; mem_op_i = 3'd0; result_i = 32'd0;
    store_data_i = 32'd0; rd_addr_i = 5'd0; wen_i = 1'b0;
  endtask

  logic [31:0] nd [4];
  logic [4:0]  nr [4];

  initial begin
    nd[0] = 32'h1111_0001; nr[0] = 5'd1;
    nd[1] = 32'h2222_0002; nr[1] = 5'd2;
    nd[2] = 32'h3333_0003; nr[2] = 5'd3;
    nd[3] = 32'h4444_0004; nr[3] = 5'd31;

    // Reset and first op
    #2;
    chk("rst_wb_v", {31'd0, wb_v_o}, 32'd0);
    chk("rst_dmem_v", {31'd0, dmem_v_o}, 32'd0);
    chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
    chk("rst_data_outs", dmem_addr_o | dmem_data_o | wb_data_o | {27'd0, wb_addr_o} | {28'd0, dmem_mask_o} | {31'd0, dmem_w_o}, 32'd0);
    tick(); tick();
    #2 n_reset = 1'b1;
    tick();
    chk("ready_after_rst", {31'd0, ready_o}, 32'd1);
    $display("txn reset released ready=%0b", ready_o);

    send(3'd0, 32'hDEADBEEF, 32'd0, 5'd5, 1'b1);
    tick();
    idle_in();
    chk("none_wb_v", {31'd0, wb_v_o}, 32'd1);
    chk("none_wb_addr", {27'd0, wb_addr_o}, 32'd5);
    chk("none_wb_data", wb_data_o, 32'hDEADBEEF);
    $display("txn NONE rd=5 wb_data=%h", wb_data_o);
    tick();
    chk("none_wb_pulse_end", {31'd0, wb_v_o}, 32'd0);

    // Back-to-back NONE
    for (int i = 0; i < 4; i++) begin
      send(3'd0, nd[i], 32'd0, nr[i], 1'b1);
      chk($sformatf("b2b_ready%0d", i), {31'd0, ready_o}, 32'd1);
      tick();
      chk($sformatf("b2b_wb_v%0d", i), {31'd0, wb_v_o}, 32'd1);
      chk($sformatf("b2b_wb_addr%0d", i), {27'd0, wb_addr_o}, {27'd0, nr[i]});
      chk($sformatf("b2b_wb_data%0d", i), wb_data_o, nd[i]);
      $display("txn NONE b2b %0d rd=%0d wb_data=%h", i, wb_addr_o, wb_data_o);
    end
    idle_in();
    tick();
    chk("b2b_end", {31'd0, wb_v_o}, 32'd0);

    // LBU with yumi after two cycles
    send(3'd2, 32'h0000_0102, 32'd0, 5'd7, 1'b1);
    tick();
    idle_in();
    chk("lbu_req_v", {31'd0, dmem_v_o}, 32'd1);
    chk("lbu_req_addr", dmem_addr_o, 32'h0000_0100);
    chk("lbu_req_w", {31'd0, dmem_w_o}, 32'd0);
    chk("lbu_req_mask", {28'd0, dmem_mask_o}, 32'd0);
    chk("lbu_busy", {31'd0, ready_o}, 32'd0);
    tick();
    chk("lbu_hold_v", {31'd0, dmem_v_o}, 32'd1);
    dmem_yumi_i = 1'b1;
    tick();
    dmem_yumi_i = 1'b0;
    chk("lbu_resp_v_low", {31'd0, dmem_v_o}, 32'd0);
    chk("lbu_resp_no_wb", {31'd0, wb_v_o}, 32'd0);
    dmem_v_i = 1'b1; dmem_data_i = 32'hAABBCCDD;
    tick();
    dmem_v_i = 1'b0; dmem_data_i = 32'd0;
    chk("lbu_wb_v", {31'd0, wb_v_o}, 32'd1);
    chk("lbu_wb_addr", {27'd0, wb_addr_o}, 32'd7);
    chk("lbu_wb_data", wb_data_o, 32'h0000_00BB);
    chk("lbu_wb_busy", {31'd0, ready_o}, 32'd0);
    $display("txn LBU addr=00000102 wb_data=%h", wb_data_o);
    tick();
    chk("lbu_done_wb", {31'd0, wb_v_o}, 32'd0);
    chk("lbu_done_ready", {31'd0, ready_o}, 32'd1);

    // SB with yumi held off for three cycles
    send(3'd4, 32'h0000_0013, 32'h0000_005A, 5'd9, 1'b1);
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sb_v%0d", i), {31'd0, dmem_v_o}, 32'd1);
      chk($sformatf("sb_w%0d", i), {31'd0, dmem_w_o}, 32'd1);
      chk($sformatf("sb_addr%0d", i), dmem_addr_o, 32'h0000_0010);
      chk($sformatf("sb_mask%0d", i), {28'd0, dmem_mask_o}, 32'h8);
      chk($sformatf("sb_data%0d", i), dmem_data_o, 32'h5A5A5A5A);
      chk($sformatf("sb_no_wb%0d", i), {31'd0, wb_v_o}, 32'd0);
      if (i == 3) dmem_yumi_i = 1'b1;
      tick();
    end
    dmem_yumi_i = 1'b0;
    chk("sb_done_v", {31'd0, dmem_v_o}, 32'd0);
    chk("sb_done_ready", {31'd0, ready_o}, 32'd1);
    chk("sb_done_no_wb", {31'd0, wb_v_o}, 32'd0);
    $display("txn SB addr=00000013 mask=1000 data=5a5a5a5a");
    tick();
    chk("sb_after_no_wb", {31'd0, wb_v_o}, 32'd0);

    // SW with immediate yumi
    send(3'd3, 32'h0000_0024, 32'hCAFE_1234, 5'd4, 1'b1);
    tick();
    idle_in();
    chk("sw_mask", {28'd0, dmem_mask_o}, 32'hF);
    chk("sw_data", dmem_data_o, 32'hCAFE_1234);
    chk("sw_addr", dmem_addr_o, 32'h0000_0024);
    dmem_yumi_i = 1'b1;
    tick();
    dmem_yumi_i = 1'b0;
    chk("sw_done_ready", {31'd0, ready_o}, 32'd1);
    chk("sw_no_wb", {31'd0, wb_v_o}, 32'd0);
    $display("txn SW addr=00000024 data=cafe1234");

    // Aligned LW at minimum latency
    send(3'd1, 32'h0000_0044, 32'd0, 5'd0, 1'b1);
    tick();
    idle_in();
    dmem_yumi_i = 1'b1;
    tick();
    dmem_yumi_i = 1'b0;
    dmem_v_i = 1'b1; dmem_data_i = 32'h89AB_CDEF;
    tick();
    dmem_v_i = 1'b0; dmem_data_i = 32'd0;
    chk("lw_wb_v", {31'd0, wb_v_o}, 32'd1);
    chk("lw_wb_addr", {27'd0, wb_addr_o}, 32'd0);
    chk("lw_wb_data", wb_data_o, 32'h89AB_CDEF);
    $display("txn LW addr=00000044 wb_data=%h", wb_data_o);
    tick();

    // Misaligned LW
    send(3'd1, 32'h0000_0006, 32'd0, 5'd3, 1'b1);
    tick();
    idle_in();
    chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
    chk("mis_no_req", {31'd0, dmem_v_o}, 32'd0);
    chk("mis_no_wb", {31'd0, wb_v_o}, 32'd0);
    chk("mis_ready", {31'd0, ready_o}, 32'd1);
    tick();
    chk("mis_pulse_end", {31'd0, misalign_o}, 32'd0);
    chk("mis_no_req2", {31'd0, dmem_v_o}, 32'd0);
    chk("mis_no_wb2", {31'd0, wb_v_o}, 32'd0);
    $display("txn LW misaligned addr=00000006");

    // Reset while waiting for a load response
    send(3'd1, 32'h0000_0020, 32'd0, 5'd9, 1'b1);
    tick();
    idle_in();
    dmem_yumi_i = 1'b1;
    tick();
    dmem_yumi_i = 1'b0;
    chk("rl_in_resp", {31'd0, ready_o}, 32'd0);
    #2 n_reset = 1'b0;
    #1;
    chk("rl_rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rl_rst_dmem_v", {31'd0, dmem_v_o}, 32'd0);
    chk("rl_rst_addr", dmem_addr_o, 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    dmem_v_i = 1'b1; dmem_data_i = 32'h1234_5678;
    tick();
    dmem_v_i = 1'b0; dmem_data_i = 32'd0;
    chk("rl_late_no_wb", {31'd0, wb_v_o}, 32'd0);
    chk("rl_late_ready", {31'd0, ready_o}, 32'd1);
    tick();
    chk("rl_late_no_wb2", {31'd0, wb_v_o}, 32'd0);
    send(3'd0, 32'hCAFEF00D, 32'd0, 5'd12, 1'b1);
    tick();
    idle_in();
    chk("rl_next_wb_v", {31'd0, wb_v_o}, 32'd1);
    chk("rl_next_wb_addr", {27'd0, wb_addr_o}, 32'd12);
    chk("rl_next_wb_data", wb_data_o, 32'hCAFEF00D);
    $display("txn NONE after reset rd=12 wb_data=%h", wb_data_o);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
